// File: rtl/lifo_stack_pkg.sv
// lifo_stack_pkg: shared types and constants for the lifo_stack block.
// Holds the operation encoding, default geometry and the count-width helper.
package lifo_stack_pkg;

  // Default geometry of the stack.
  localparam int DEF_WIDTH = 12;
  localparam int DEF_DEPTH = 8;

  // Per-cycle operation, encoded directly as {push, pop}.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } op_e;

  // Bits needed to hold an occupancy in the range 0..depth.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage : lifo_stack_pkg

// File: rtl/lifo_stack_if.sv
// lifo_stack_if: control/data bundle between the fetch logic (master) and the
// return-address stack (slave). clk and rst stay outside as plain ports.
interface lifo_stack_if
  import lifo_stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int CW = count_width(DEPTH);

  logic             flush;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] push_data;
  logic             clr_flags;
  logic [WIDTH-1:0] pop_data;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, push, pop, push_data, clr_flags,
    input  pop_data, empty, full, count, overflow, underflow
  );

  modport slave (
    input  flush, push, pop, push_data, clr_flags,
    output pop_data, empty, full, count, overflow, underflow
  );

endinterface : lifo_stack_if

// File: rtl/lifo_stack_mem.sv
// lifo_stack_mem: DEPTH x WIDTH register array, one synchronous write port and
// one asynchronous read port. Contents are never reset.
module lifo_stack_mem
  import lifo_stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the addressed slot on a write-enable edge.
  // NOTE: storage has no reset; occupancy alone decides what is visible, and
  // leaving it off the reset net lets it map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : lifo_stack_mem

// File: rtl/lifo_stack.sv
// lifo_stack: parametrised return-address LIFO with replace-top, occupancy
// count, full/empty, sticky overflow/underflow and synchronous flush.
// Build option: define LIFO_STACK_WRAP_EN to make storage circular, so a push
// while full overwrites the oldest entry instead of being dropped.
module lifo_stack
  import lifo_stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  lifo_stack_if.slave bus
);

  localparam int CW = count_width(DEPTH);
  localparam int PW = $clog2(DEPTH);

  // ptr_q is the next slot to write (mod DEPTH); the top lives one below it.
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             we;
  logic [PW-1:0]    waddr;
  logic [PW-1:0]    top_idx;
  logic [PW-1:0]    ptr_inc, ptr_dec;
  logic [WIDTH-1:0] rdata;
  logic             is_empty, is_full;
  op_e              op;

  assign op       = op_e'({bus.push, bus.pop});
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign ptr_inc  = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  assign ptr_dec  = (ptr_q == '0) ? PW'(DEPTH - 1) : ptr_q - 1'b1;
  assign top_idx  = ptr_dec;

  // Next-state for count, pointer, write port and sticky flags.
  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    ptr_d   = ptr_q;
    we      = 1'b0;
    waddr   = ptr_q;
    // A flag set later in this block overrides the clear.
    ovf_d   = bus.clr_flags ? 1'b0 : ovf_q;
    unf_d   = bus.clr_flags ? 1'b0 : unf_q;

    if (bus.flush) begin
      count_d = '0;
      ptr_d   = '0;
    end else begin
      unique case (op)
        OP_PUSH: begin
          if (!is_full) begin
            we      = 1'b1;
            ptr_d   = ptr_inc;
            count_d = count_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
`ifdef LIFO_STACK_WRAP_EN
            // When full, ptr_q sits on the oldest entry: overwrite it.
            we    = 1'b1;
            ptr_d = ptr_inc;
`endif
          end
        end
        OP_POP: begin
          if (!is_empty) begin
            ptr_d   = ptr_dec;
            count_d = count_q - 1'b1;
          end else begin
            unf_d = 1'b1;
          end
        end
        OP_REPL: begin
          if (!is_empty) begin
            we    = 1'b1;
            waddr = top_idx;
          end else begin
            we      = 1'b1;
            ptr_d   = ptr_inc;
            count_d = CW'(1);
            unf_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers; reset empties the stack and clears both flags.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  lifo_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (bus.push_data),
    .raddr_i (top_idx),
    .rdata_o (rdata)
  );

  assign bus.pop_data  = is_empty ? '0 : rdata;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule : lifo_stack

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: directed self-checking bench for lifo_stack (WIDTH=12, DEPTH=8).
module tb_lifo_stack;

  localparam int WIDTH = 12;
  localparam int DEPTH = 8;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  lifo_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.flush     = 1'b0;
    bus.clr_flags = 1'b0;
    bus.push_data = '0;
  endtask

  task automatic check_flags(input string tag, input logic ovf, input logic unf);
    check({tag, "_ovf"}, 32'(bus.overflow), 32'(ovf));
    check({tag, "_unf"}, 32'(bus.underflow), 32'(unf));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    idle();
    rst = 1'b0;
    #12;
    // Reset state
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_pop_data", 32'(bus.pop_data), 32'd0);
    check_flags("rst", 1'b0, 1'b0);
    rst = 1'b1;
    tick();

    // 1: fill with 1..8, then drain in reverse order
    for (int i = 1; i <= DEPTH; i++) begin
      bus.push = 1'b1;
      bus.push_data = 12'(i);
      tick();
      check("t1_fill_count", 32'(bus.count), 32'(i));
      check("t1_fill_top", 32'(bus.pop_data), 32'(i));
    end
    idle();
    check("t1_full", 32'(bus.full), 32'd1);
    bus.pop = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      check("t1_drain_top", 32'(bus.pop_data), 32'(DEPTH - k));
      tick();
    end
    idle();
    check("t1_empty", 32'(bus.empty), 32'd1);
    check("t1_empty_data", 32'(bus.pop_data), 32'd0);
    check("t1_empty_count", 32'(bus.count), 32'd0);
    check_flags("t1", 1'b0, 1'b0);

    // 2: push while full
    for (int i = 1; i <= DEPTH; i++) begin
      bus.push = 1'b1;
      bus.push_data = 12'(i);
      tick();
    end
    bus.push_data = 12'hABC;
    tick();
    idle();
    check("t2_count", 32'(bus.count), 32'd8);
    check("t2_full", 32'(bus.full), 32'd1);
    check_flags("t2", 1'b1, 1'b0);
    bus.pop = 1'b1;
`ifdef LIFO_STACK_WRAP_EN
    check("t2_top", 32'(bus.pop_data), 32'hABC);
    tick();
    for (int k = 8; k >= 2; k--) begin
      check("t2_wrap_drain", 32'(bus.pop_data), 32'(k));
      tick();
    end
`else
    check("t2_top", 32'(bus.pop_data), 32'h008);
    for (int k = 8; k >= 1; k--) begin
      check("t2_lin_drain", 32'(bus.pop_data), 32'(k));
      tick();
    end
`endif
    idle();
    check("t2_empty", 32'(bus.empty), 32'd1);
    bus.clr_flags = 1'b1;
    tick();
    idle();
    check_flags("t2_clr", 1'b0, 1'b0);

    // 3: underflow, clear, and set-beats-clear
    bus.pop = 1'b1;
    tick();
    idle();
    check("t3_count", 32'(bus.count), 32'd0);
    check_flags("t3_pop_empty", 1'b0, 1'b1);
    bus.clr_flags = 1'b1;
    tick();
    idle();
    check_flags("t3_clr", 1'b0, 1'b0);
    bus.pop = 1'b1;
    bus.clr_flags = 1'b1;
    tick();
    idle();
    check_flags("t3_set_wins", 1'b0, 1'b1);
    bus.clr_flags = 1'b1;
    tick();
    idle();

    // 4: replace top, and push+pop on empty
    bus.push = 1'b1;
    bus.push_data = 12'h111;
    tick();
    bus.push_data = 12'h222;
    tick();
    bus.pop = 1'b1;
    bus.push_data = 12'h333;
    tick();
    idle();
    check("t4_repl_count", 32'(bus.count), 32'd2);
    check("t4_repl_top", 32'(bus.pop_data), 32'h333);
    check_flags("t4_repl", 1'b0, 1'b0);
    bus.pop = 1'b1;
    tick();
    check("t4_below", 32'(bus.pop_data), 32'h111);
    tick();
    idle();
    check("t4_drained", 32'(bus.empty), 32'd1);
    bus.push = 1'b1;
    bus.pop = 1'b1;
    bus.push_data = 12'h444;
    tick();
    idle();
    check("t4_pp_empty_count", 32'(bus.count), 32'd1);
    check("t4_pp_empty_top", 32'(bus.pop_data), 32'h444);
    check_flags("t4_pp_empty", 1'b0, 1'b1);

    // 5: flush beats push; flags untouched (underflow still set from step 4)
    bus.push = 1'b1;
    bus.push_data = 12'h0A1;
    tick();
    bus.push_data = 12'h0A2;
    tick();
    check("t5_pre_count", 32'(bus.count), 32'd3);
    bus.flush = 1'b1;
    bus.push_data = 12'h555;
    tick();
    idle();
    check("t5_flush_count", 32'(bus.count), 32'd0);
    check("t5_flush_empty", 32'(bus.empty), 32'd1);
    check_flags("t5_flush", 1'b0, 1'b1);
    bus.push = 1'b1;
    bus.push_data = 12'h666;
    tick();
    idle();
    check("t5_after_top", 32'(bus.pop_data), 32'h666);
    check("t5_after_count", 32'(bus.count), 32'd1);

    // 6: async reset mid-cycle with 5 entries and underflow set
    bus.push = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.push_data = 12'(12'h0B0 + i);
      tick();
    end
    idle();
    check("t6_pre_count", 32'(bus.count), 32'd5);
    #3;
    rst = 1'b0;
    #1;
    check("t6_rst_count", 32'(bus.count), 32'd0);
    check("t6_rst_empty", 32'(bus.empty), 32'd1);
    check("t6_rst_data", 32'(bus.pop_data), 32'd0);
    check_flags("t6_rst", 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    bus.push = 1'b1;
    bus.push_data = 12'h777;
    tick();
    idle();
    check("t6_post_count", 32'(bus.count), 32'd1);
    check("t6_post_top", 32'(bus.pop_data), 32'h777);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_lifo_stack
